// File: rtl/vx_decode_ibuf.sv
// Multi-warp instruction buffer between decode and issue: per-warp FIFOs feeding
// ISSUE_WIDTH round-robin issue slots, with per-warp flush.
module vx_decode_ibuf #(
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DATA_WIDTH  = 64,
    localparam int unsigned NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int unsigned CNT_BITS   = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [NW_BITS-1:0]                in_wid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              in_ready,
    input  logic [NUM_WARPS-1:0]              flush_mask,
    output logic [ISSUE_WIDTH-1:0]            out_valid,
    output logic [ISSUE_WIDTH*NW_BITS-1:0]    out_wid,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_data,
    input  logic [ISSUE_WIDTH-1:0]            out_ready,
    output logic [ISSUE_WIDTH-1:0]            ibuf_pop,
    output logic [NUM_WARPS-1:0]              empty_mask
);

    localparam int unsigned WPS      = NUM_WARPS / ISSUE_WIDTH;
    localparam int unsigned SL_BITS  = (WPS > 1) ? $clog2(WPS) : 1;
    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WARPS][DEPTH];

    logic [CNT_BITS-1:0] count_q  [NUM_WARPS];
    logic [CNT_BITS-1:0] count_d  [NUM_WARPS];
    logic [PTR_BITS-1:0] rd_ptr_q [NUM_WARPS];
    logic [PTR_BITS-1:0] rd_ptr_d [NUM_WARPS];
    logic [PTR_BITS-1:0] wr_ptr_q [NUM_WARPS];
    logic [PTR_BITS-1:0] wr_ptr_d [NUM_WARPS];

    logic [SL_BITS-1:0] rr_q       [ISSUE_WIDTH];
    logic [SL_BITS-1:0] rr_d       [ISSUE_WIDTH];
    logic [SL_BITS-1:0] lock_idx_q [ISSUE_WIDTH];
    logic [SL_BITS-1:0] lock_idx_d [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] lock_q, lock_d;

    logic [WPS-1:0]     elig      [ISSUE_WIDTH];
    logic [SL_BITS-1:0] grant_idx [ISSUE_WIDTH];
    logic [NW_BITS-1:0] grant_wid [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] slot_valid, fire;

    logic                 push_fire;
    logic [NUM_WARPS-1:0] push_w, pop_w;

    // First eligible slot-local index at or after ptr, wrapping.
    function automatic logic [SL_BITS-1:0] rr_pick(input logic [WPS-1:0] el,
                                                   input logic [SL_BITS-1:0] ptr);
        logic [SL_BITS-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < WPS; k++) begin
            idx = (int'(ptr) + k) % WPS;
            if (!found && el[idx]) begin
                found = 1'b1;
                pick  = SL_BITS'(idx);
            end
        end
        return pick;
    endfunction

    assign in_ready  = (count_q[in_wid] < CNT_BITS'(DEPTH)) && !flush_mask[in_wid];
    assign push_fire = in_valid && in_ready;

    always_comb begin
        out_wid  = '0;
        out_data = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            elig[s] = '0;
            for (int k = 0; k < WPS; k++) begin
                elig[s][k] = (count_q[k * ISSUE_WIDTH + s] != '0);
            end
            slot_valid[s] = |elig[s];
            // A stalled slot keeps its presented warp until it is consumed or flushed.
            grant_idx[s]  = lock_q[s] ? lock_idx_q[s] : rr_pick(elig[s], rr_q[s]);
            grant_wid[s]  = NW_BITS'(int'(grant_idx[s]) * ISSUE_WIDTH + s);
            fire[s]       = slot_valid[s] && out_ready[s];
            out_wid[s*NW_BITS +: NW_BITS]        = grant_wid[s];
            out_data[s*DATA_WIDTH +: DATA_WIDTH] = mem_q[grant_wid[s]][rd_ptr_q[grant_wid[s]]];

            rr_d[s] = rr_q[s];
            if (fire[s]) begin
                rr_d[s] = (grant_idx[s] == SL_BITS'(WPS - 1)) ? '0 : grant_idx[s] + 1'b1;
            end
            lock_d[s]     = slot_valid[s] && !out_ready[s] && !flush_mask[grant_wid[s]];
            lock_idx_d[s] = grant_idx[s];
        end
    end

    assign out_valid = slot_valid;
    assign ibuf_pop  = fire;

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_w[w]   = push_fire && (in_wid == NW_BITS'(w));
            pop_w[w]    = fire[w % ISSUE_WIDTH] && (grant_wid[w % ISSUE_WIDTH] == NW_BITS'(w));
            count_d[w]  = count_q[w];
            rd_ptr_d[w] = rd_ptr_q[w];
            wr_ptr_d[w] = wr_ptr_q[w];
            if (push_w[w]) begin
                wr_ptr_d[w] = wr_ptr_q[w] + 1'b1;
            end
            // Flush wins over a same-cycle pop; push is already blocked by in_ready.
            if (flush_mask[w]) begin
                count_d[w]  = '0;
                rd_ptr_d[w] = wr_ptr_q[w];
            end else begin
                if (push_w[w] && !pop_w[w]) begin
                    count_d[w] = count_q[w] + 1'b1;
                end else if (pop_w[w] && !push_w[w]) begin
                    count_d[w] = count_q[w] - 1'b1;
                end
                if (pop_w[w]) begin
                    rd_ptr_d[w] = rd_ptr_q[w] + 1'b1;
                end
            end
            empty_mask[w] = (count_q[w] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w]  <= '0;
                rd_ptr_q[w] <= '0;
                wr_ptr_q[w] <= '0;
            end
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                rr_q[s]       <= '0;
                lock_idx_q[s] <= '0;
            end
            lock_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w]  <= count_d[w];
                rd_ptr_q[w] <= rd_ptr_d[w];
                wr_ptr_q[w] <= wr_ptr_d[w];
            end
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                rr_q[s]       <= rr_d[s];
                lock_idx_q[s] <= lock_idx_d[s];
            end
            lock_q <= lock_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[in_wid][wr_ptr_q[in_wid]] <= in_data;
        end
    end

endmodule

// File: tb/tb_vx_decode_ibuf.sv
// Directed bench for vx_decode_ibuf: scoreboard of expected issues per slot,
// checked whenever the DUT pulses ibuf_pop, plus point checks on each scenario.
module tb_vx_decode_ibuf;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   in_wid;
    logic [63:0]  in_data;
    logic         in_ready;
    logic [3:0]   flush_mask;
    logic [1:0]   out_valid;
    logic [3:0]   out_wid;
    logic [127:0] out_data;
    logic [1:0]   out_ready;
    logic [1:0]   ibuf_pop;
    logic [3:0]   empty_mask;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [1:0]  wid;
        logic [63:0] data;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];

    vx_decode_ibuf #(
        .NUM_WARPS  (4),
        .ISSUE_WIDTH(2),
        .DEPTH      (4),
        .DATA_WIDTH (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_wid    (in_wid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush_mask(flush_mask),
        .out_valid (out_valid),
        .out_wid   (out_wid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ibuf_pop  (ibuf_pop),
        .empty_mask(empty_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dv(input int w, input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(w) << 16) | 64'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input int s, input logic [1:0] w, input logic [63:0] d);
        ent_t e;
        e.wid  = w;
        e.data = d;
        if (s == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic check_pops();
        ent_t e;
        int   sz;
        for (int s = 0; s < 2; s++) begin
            if (ibuf_pop[s]) begin
                chk("pop_without_fire", 64'(out_valid[s] & out_ready[s]), 64'd1);
                sz = (s == 0) ? q0.size() : q1.size();
                nvec++;
                assert (sz != 0) else begin
                    nerr++;
                    $error("FAIL pop_unexpected slot %0d: queue size %0d, required nonzero", s, sz);
                end
                if (sz != 0) begin
                    if (s == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk("sb_wid", 64'(out_wid[s*2 +: 2]), 64'(e.wid));
                    chk("sb_data", out_data[s*64 +: 64], e.data);
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic tick();
        check_pops();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    task automatic push(input logic [1:0] w, input logic [63:0] d, input logic exp_rdy);
        in_valid = 1'b1;
        in_wid   = w;
        in_data  = d;
        sample();
        chk("push_ready", 64'(in_ready), 64'(exp_rdy));
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_wid     = 2'd0;
        in_data    = '0;
        flush_mask = '0;
        out_ready  = '0;

        // Reset state
        sample();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ibuf_pop", 64'(ibuf_pop), 64'd0);
        chk("rst_empty", 64'(empty_mask), 64'hF);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b1;
        cycle();

        // Fairness on slot 0: w0 and w2 alternate starting from w0
        for (int i = 0; i < 3; i++) push(2'd0, dv(0, i), 1'b1);
        for (int i = 0; i < 3; i++) push(2'd2, dv(2, i), 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_issue(0, 2'd0, dv(0, i));
            expect_issue(0, 2'd2, dv(2, i));
        end
        out_ready = 2'b01;
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("fair_wid", 64'(out_wid[1:0]), (i % 2 == 0) ? 64'd0 : 64'd2);
            chk("fair_pop", 64'(ibuf_pop[0]), 64'd1);
            tick();
        end
        sample();
        chk("fair_drained", 64'(out_valid[0]), 64'd0);
        tick();

        // Single push w0: visible next cycle, empty the cycle after
        in_valid = 1'b1;
        in_wid   = 2'd0;
        in_data  = dv(0, 9);
        expect_issue(0, 2'd0, dv(0, 9));
        sample();
        chk("single_in_ready", 64'(in_ready), 64'd1);
        chk("single_no_bypass", 64'(out_valid[0]), 64'd0);
        tick();
        in_valid = 1'b0;
        sample();
        chk("single_valid", 64'(out_valid[0]), 64'd1);
        chk("single_wid", 64'(out_wid[1:0]), 64'd0);
        chk("single_pop", 64'(ibuf_pop[0]), 64'd1);
        tick();
        sample();
        chk("single_empty", 64'(empty_mask[0]), 64'd1);
        chk("single_idle", 64'(out_valid[0]), 64'd0);
        tick();
        out_ready = 2'b00;

        // Stall lock: w0 presented, w2 pushed behind it while rr points at w2
        expect_issue(0, 2'd0, dv(0, 20));
        expect_issue(0, 2'd2, dv(2, 21));
        push(2'd0, dv(0, 20), 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 0);
            in_wid   = 2'd2;
            in_data  = dv(2, 21);
            sample();
            chk("lock_valid", 64'(out_valid[0]), 64'd1);
            chk("lock_wid", 64'(out_wid[1:0]), 64'd0);
            chk("lock_data", out_data[63:0], dv(0, 20));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 2'b01;
        sample();
        chk("lock_rel_wid0", 64'(out_wid[1:0]), 64'd0);
        tick();
        sample();
        chk("lock_rel_wid2", 64'(out_wid[1:0]), 64'd2);
        tick();
        out_ready = 2'b00;
        sample();
        chk("lock_empty", 64'(empty_mask), 64'hF);
        tick();

        // Fill w1, refuse a push while full even with a same-cycle pop, drain in order
        for (int i = 0; i < 4; i++) begin
            push(2'd1, dv(1, i), 1'b1);
            expect_issue(1, 2'd1, dv(1, i));
        end
        in_valid  = 1'b1;
        in_wid    = 2'd1;
        in_data   = dv(1, 4);
        out_ready = 2'b10;
        sample();
        chk("full_refuse", 64'(in_ready), 64'd0);
        chk("full_pop", 64'(ibuf_pop[1]), 64'd1);
        tick();
        in_valid = 1'b0;
        sample();
        chk("after_pop_ready", 64'(in_ready), 64'd1);
        tick();
        cycle();
        cycle();
        out_ready = 2'b00;
        sample();
        chk("fill_empty", 64'(empty_mask[1]), 64'd1);
        tick();

        // Flush w3 while it is granted and firing
        for (int i = 0; i < 3; i++) push(2'd3, dv(3, i), 1'b1);
        expect_issue(1, 2'd3, dv(3, 0));
        flush_mask = 4'b1000;
        in_valid   = 1'b1;
        in_wid     = 2'd3;
        in_data    = dv(3, 7);
        out_ready  = 2'b10;
        sample();
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        chk("flush_pop", 64'(ibuf_pop[1]), 64'd1);
        chk("flush_wid", 64'(out_wid[3:2]), 64'd3);
        tick();
        flush_mask = '0;
        in_valid   = 1'b0;
        sample();
        chk("flush_empty", 64'(empty_mask), 64'hF);
        chk("flush_valid", 64'(out_valid[1]), 64'd0);
        tick();
        expect_issue(1, 2'd3, dv(3, 8));
        push(2'd3, dv(3, 8), 1'b1);
        sample();
        chk("flush_fresh_data", out_data[127:64], dv(3, 8));
        tick();
        out_ready = 2'b00;
        cycle();

        // Asynchronous reset mid-stream
        push(2'd0, dv(0, 30), 1'b1);
        push(2'd1, dv(1, 31), 1'b1);
        push(2'd2, dv(2, 32), 1'b1);
        in_valid = 1'b1;
        in_wid   = 2'd0;
        in_data  = dv(0, 33);
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd3);
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_empty", 64'(empty_mask), 64'hF);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_ibuf_pop", 64'(ibuf_pop), 64'd0);
        in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        out_ready = 2'b11;
        expect_issue(1, 2'd1, dv(1, 40));
        push(2'd1, dv(1, 40), 1'b1);
        sample();
        chk("post_rst_valid", 64'(out_valid), 64'd2);
        chk("post_rst_data", out_data[127:64], dv(1, 40));
        tick();
        out_ready = 2'b00;
        cycle();

        chk("sb_q0_drained", 64'(q0.size()), 64'd0);
        chk("sb_q1_drained", 64'(q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vx_decode_ibuf.md
Name: vx_decode_ibuf

Overview:
- Multi-warp instruction buffer between decode and issue.
- Accepts decoded instructions one per cycle through a valid/ready handshake, keyed by warp id, into per-warp FIFOs of configurable depth.
- Presents ISSUE_WIDTH independent issue slots. Each slot round-robin arbitrates among its own warps and pulses a per-slot ibuf_pop on every dequeue.
- Supports per-warp flush (for branch mispredict / warp kill).

Parameters:
- NUM_WARPS, 4, warps buffered; must be a multiple of ISSUE_WIDTH.
- ISSUE_WIDTH, 2, issue slots; warp w maps to slot w % ISSUE_WIDTH.
- DEPTH, 4, entries per warp FIFO; power of 2, >= 2.
- DATA_WIDTH, 64, opaque payload width (packed decode record).
- NW_BITS = max(1, clog2(NUM_WARPS)) and CNT_BITS = clog2(DEPTH+1) are derived.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction valid
- in_wid  in  NW_BITS  target warp
- in_data  in  DATA_WIDTH  payload
- in_ready  out  1  buffer of in_wid can accept
- flush_mask  in  NUM_WARPS  per-warp flush request, one-cycle pulse
- out_valid  out  ISSUE_WIDTH  per-slot instruction available
- out_wid  out  ISSUE_WIDTH*NW_BITS  per-slot warp id of presented entry
- out_data  out  ISSUE_WIDTH*DATA_WIDTH  per-slot payload
- out_ready  in  ISSUE_WIDTH  per-slot consumer ready
- ibuf_pop  out  ISSUE_WIDTH  per-slot dequeue pulse
- empty_mask  out  NUM_WARPS  per-warp FIFO empty

Behaviour:
- Reset (reset=0, asynchronous):
  - all counts, read/write pointers and RR pointers go to 0.
  - out_valid=0, ibuf_pop=0, empty_mask=all ones, in_ready=1.
  - Reset mid-operation discards all contents; FIFO storage need not be cleared.
- Push:
  - in_ready = (count[in_wid] < DEPTH) && !flush_mask[in_wid].
  - Push fire = in_valid && in_ready. Data is written at the write pointer, the pointer increments mod DEPTH, and count increments.
  - No full-bypass: a full warp deasserts in_ready even if the same warp is popped that cycle.
- Latency: an entry pushed in cycle N is visible on out_valid no earlier than cycle N+1. There is no combinational in-to-out path.
- Slot arbitration (per slot s, candidate warps w with w % ISSUE_WIDTH == s):
  - Eligible = count[w] != 0.
  - Grant is the first eligible warp at or after rr_ptr[s] in slot-local order.
  - out_valid[s] = any eligible. out_wid and out_data come from the granted warp's head.
  - Lock: while out_valid[s] && !out_ready[s], the grant must not change and out_wid/out_data stay stable. A push to another warp in the slot does not steal the grant.
  - On pop fire (out_valid[s] && out_ready[s]): the read pointer increments, count decrements, rr_ptr[s] moves to the slot-local index after the granted warp (wraps), and ibuf_pop[s]=1 in the same cycle (combinational with fire).
  - ibuf_pop is never asserted without fire.
- Simultaneous push and pop on the same warp: count unchanged, both pointers advance. Legal at any count except full, where no push is accepted.
- Flush (flush_mask[w]=1, effective at the next clock edge):
  - count[w] := 0; read pointer := write pointer.
  - in_ready=0 for w that cycle, so no push to w is accepted.
  - If w is granted and fires the same cycle, ibuf_pop still pulses. The flush result (empty) takes priority over the decrement.
  - rr_ptr is unaffected.
- Counter widths: count is CNT_BITS wide and saturates by construction (push blocked at DEPTH, pop blocked at 0).
- empty_mask[w] = (count[w]==0), registered-state derived.

Test Plan:
- Single push w0 with out_ready=1: push in cycle 0 -> out_valid[0]=1 and out_wid[0]=0 in cycle 1, ibuf_pop[0]=1 in cycle 1, empty_mask[0]=1 in cycle 2.
- Fill w1 with 4 entries (DEPTH=4): in_ready drops after the 4th push. A 5th push with a same-cycle pop is still refused. After the pop, in_ready=1 and data drains in order D0..D3.
- Fairness on slot 0: w0 and w2 each hold 3 entries, out_ready[0]=1 -> out_wid sequence 0,2,0,2,0,2; ibuf_pop[0] is high for 6 consecutive cycles.
- Stall lock: w0 presented with out_ready=0 for 5 cycles while w2 is pushed -> out_wid/out_data hold w0's head throughout; after ready, w0 pops, then w2.
- Flush while w3 holds 3 entries and is granted with out_ready[1]=1 -> ibuf_pop[1]=1 that cycle; next cycle count[w3]=0, empty_mask[3]=1, out_valid[1]=0 (if w1 is empty). A concurrent in_valid to w3 is refused.
- Assert reset mid-stream with warps partially full -> outputs go to reset values immediately (asynchronous). After release, the first push returns only new data.
